// File: rtl/delay_line_pkg.sv
// Shared types and sizing helpers for the delay_line_ram circular-buffer delay line.
package delay_line_pkg;

  typedef enum logic {FILL, RUN} dl_state_t;

  // Source of the delayed sample captured on a strobe.
  typedef enum logic [1:0] {SEL_ZERO, SEL_BYP, SEL_RAM} dl_sel_t;

  localparam int DL_DEFAULT_AW = 8;

  function automatic int dl_depth(input int aw);
    return 1 << aw;
  endfunction

  function automatic int dl_max_delay(input int aw);
    return dl_depth(aw) - 1;
  endfunction

endpackage

// File: rtl/sdp_ram_core.sv
// Simple dual-port synchronous RAM; no reset, returns old data on a same-address read/write.
module sdp_ram_core #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     rd_en,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    dout
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= din;
    end
    if (rd_en) begin
      r_q <= r_mem[rd_addr];
    end
  end

  assign dout = r_q;

endmodule

// File: rtl/delay_line_ram.sv
// Circular-buffer delay line: returns the sample written `delay` strobes earlier.
// Optional extra output register stage when DELAY_LINE_RAM_OUTREG_EN is defined.
module delay_line_ram
  import delay_line_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DL_DEFAULT_AW,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [ADDRESS_WIDTH-1:0] delay,
  input  logic [DATA_WIDTH-1:0]    din,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     dout_valid,
  output logic                     primed
);

  localparam logic [ADDRESS_WIDTH-1:0] FILL_MAX = ADDRESS_WIDTH'(dl_max_delay(ADDRESS_WIDTH));

  logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
  logic [ADDRESS_WIDTH-1:0] r_fill_cnt;
  logic [ADDRESS_WIDTH-1:0] w_fill_next;
  logic [ADDRESS_WIDTH-1:0] w_rd_addr;
  dl_state_t                r_state;
  dl_state_t                w_state_next;
  dl_sel_t                  r_sel_p1;
  logic                     r_vld_p1;
  logic [DATA_WIDTH-1:0]    r_byp_p1;
  logic [DATA_WIDTH-1:0]    w_ram_q;
  logic [DATA_WIDTH-1:0]    w_dout_p1;

  assign w_rd_addr = r_wr_ptr - delay;

  always_comb begin
    w_fill_next = r_fill_cnt;
    if (en && (r_fill_cnt != FILL_MAX)) begin
      w_fill_next = r_fill_cnt + 1'b1;
    end
  end

  // State tracks the post-strobe fill level so the next strobe already sees RUN.
  always_comb begin
    w_state_next = r_state;
    if (w_fill_next >= delay) begin
      w_state_next = RUN;
    end else begin
      w_state_next = FILL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
      r_state    <= FILL;
      r_sel_p1   <= SEL_ZERO;
      r_vld_p1   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_fill_cnt <= w_fill_next;
      r_vld_p1   <= en;
      if (en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_state == FILL) begin
          r_sel_p1 <= SEL_ZERO;
        end else if (delay == '0) begin
          r_sel_p1 <= SEL_BYP;
        end else begin
          r_sel_p1 <= SEL_RAM;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      r_byp_p1 <= din;
    end
  end

  sdp_ram_core #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (en),
    .wr_addr (r_wr_ptr),
    .din     (din),
    .rd_en   (en),
    .rd_addr (w_rd_addr),
    .dout    (w_ram_q)
  );

  // ---- stage p1: select delayed sample (holds while en=0) ----
  always_comb begin
    w_dout_p1 = '0;
    case (r_sel_p1)
      SEL_BYP: w_dout_p1 = r_byp_p1;
      SEL_RAM: w_dout_p1 = w_ram_q;
      default: w_dout_p1 = '0;
    endcase
  end

  assign primed = (r_state == RUN);

`ifdef DELAY_LINE_RAM_OUTREG_EN
  logic [DATA_WIDTH-1:0] r_dout_p2;
  logic                  r_vld_p2;

  // ---- stage p2: optional output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout_p2 <= '0;
      r_vld_p2  <= 1'b0;
    end else begin
      r_dout_p2 <= w_dout_p1;
      r_vld_p2  <= r_vld_p1;
    end
  end

  assign dout       = r_dout_p2;
  assign dout_valid = r_vld_p2;
`else
  assign dout       = w_dout_p1;
  assign dout_valid = r_vld_p1;
`endif

endmodule

// File: tb/tb_delay_line_ram.sv
// Scoreboard bench for delay_line_ram: an AW=8 and an AW=4 instance driven by directed steps.
module tb_delay_line_ram;

`ifdef DELAY_LINE_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en8 = 1'b0, en4 = 1'b0;
  logic [7:0] delay8 = '0;
  logic [3:0] delay4 = '0;
  logic [7:0] din8 = '0, din4 = '0;
  logic [7:0] dout8, dout4;
  logic       v8, v4, pr8, pr4;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] expq [2][$];
  logic [7:0] hist [2][$];
  int         nfill [2];
  logic [1:0] sh8, sh4;

  delay_line_ram #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .delay(delay8), .din(din8),
    .dout(dout8), .dout_valid(v8), .primed(pr8));

  delay_line_ram #(.ADDRESS_WIDTH(4), .DATA_WIDTH(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .delay(delay4), .din(din4),
    .dout(dout4), .dout_valid(v4), .primed(pr4));

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      expq[i].delete();
      hist[i].delete();
      nfill[i] = 0;
    end
    sh8 = '0;
    sh4 = '0;
  endtask

  // Expected output for a strobe: 0 while fewer than `dly` samples stored, else the sample dly back.
  task automatic push_exp(input int idx, input logic [7:0] d, input int dly, input int maxd);
    logic [7:0] e;
    if (nfill[idx] >= dly) e = (dly == 0) ? d : hist[idx][hist[idx].size() - dly];
    else e = 8'h00;
    expq[idx].push_back(e);
    hist[idx].push_back(d);
    if (nfill[idx] < maxd) nfill[idx]++;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  task automatic check_out(input int idx, input logic v, input logic [7:0] d, input logic ev);
    logic [7:0] e;
    n_cmp++;
    assert (v === ev) else begin
      n_fail++;
      $error("FAIL valid%0d got %b want %b", idx, v, ev);
    end
    if (ev) begin
      if (expq[idx].size() == 0) begin
        n_cmp++;
        n_fail++;
        $error("FAIL underflow%0d got %h want none", idx, d);
      end else begin
        e = expq[idx].pop_front();
        n_cmp++;
        assert (d === e) else begin
          n_fail++;
          $error("FAIL dout%0d got %h want %h", idx, d, e);
        end
      end
    end
  endtask

  // One clock: drive at negedge, check outputs 1 time unit after the posedge.
  task automatic step(input logic e8, input logic [7:0] d8, input logic e4, input logic [7:0] d4);
    en8 = e8; din8 = d8; en4 = e4; din4 = d4;
    if (e8) push_exp(0, d8, int'(delay8), 255);
    if (e4) push_exp(1, d4, int'(delay4), 15);
    @(posedge clk);
    sh8 = {sh8[0], en8};
    sh4 = {sh4[0], en4};
    #1;
    check_out(0, v8, dout8, sh8[LAT-1]);
    check_out(1, v4, dout4, sh4[LAT-1]);
    @(negedge clk);
    en8 = 1'b0;
    en4 = 1'b0;
  endtask

  task automatic step8(input logic e, input logic [7:0] d);
    step(e, d, 1'b0, 8'h00);
  endtask

  initial begin
    model_reset();
    delay8 = 8'd3;
    delay4 = 4'd15;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_dout", dout8, 8'h00);
    chk("rst_valid", {7'b0, v8}, 8'h00);
    chk("rst_primed", {7'b0, pr8}, 8'h00);
    rst_n = 1'b1;
    step8(1'b0, 8'h00);
    chk("fill_primed0", {7'b0, pr8}, 8'h00);

    // priming with delay 3
    step8(1'b1, 8'd10);
    step8(1'b1, 8'd11);
    chk("fill_primed2", {7'b0, pr8}, 8'h00);
    step8(1'b1, 8'd12);
    chk("fill_primed3", {7'b0, pr8}, 8'h01);
    step8(1'b1, 8'd13);
    step8(1'b1, 8'd14);

    // strobe gaps: dout holds, valid only after strobes
    step8(1'b1, 8'd15);
    step8(1'b0, 8'h00);
    step8(1'b0, 8'h00);
    chk("gap_hold", dout8, 8'd12);
    step8(1'b1, 8'd16);

    // zero delay bypass
    delay8 = 8'd0;
    step8(1'b0, 8'h00);
    step8(1'b1, 8'h5A);
    step8(1'b1, 8'hA5);

    // delay change: fill to 20 at delay 5, then 30, then 2
    delay8 = 8'd5;
    step8(1'b0, 8'h00);
    for (int i = 0; i < 11; i++) step8(1'b1, 8'(100 + i));
    chk("d5_primed", {7'b0, pr8}, 8'h01);
    delay8 = 8'd30;
    step8(1'b0, 8'h00);
    chk("d30_primed_lo", {7'b0, pr8}, 8'h00);
    for (int i = 0; i < 12; i++) begin
      step8(1'b1, 8'(150 + i));
      if (i == 4) chk("d30_mid_primed", {7'b0, pr8}, 8'h00);
    end
    chk("d30_primed_hi", {7'b0, pr8}, 8'h01);
    delay8 = 8'd2;
    step8(1'b0, 8'h00);
    chk("d2_primed", {7'b0, pr8}, 8'h01);
    for (int i = 0; i < 3; i++) step8(1'b1, 8'(200 + i));

    // wrap-around on the AW=4 instance with maximum delay
    for (int i = 0; i <= 40; i++) step(1'b0, 8'h00, 1'b1, 8'(i));
    chk("wrap_primed", {7'b0, pr4}, 8'h01);
    chk("wrap_fill_sat", 8'(u_dut4.r_fill_cnt), 8'd15);

    // asynchronous reset mid-stream
    step8(1'b1, 8'h21);
    step8(1'b1, 8'h22);
    en8 = 1'b1;
    din8 = 8'hEE;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_dout", dout8, 8'h00);
    chk("mid_rst_valid", {7'b0, v8}, 8'h00);
    chk("mid_rst_primed", {7'b0, pr8}, 8'h00);
    @(negedge clk);
    en8 = 1'b0;
    delay8 = 8'd1;
    rst_n = 1'b1;
    sh8 = '0;
    sh4 = '0;
    step8(1'b0, 8'h00);
    chk("rel_wr_ptr", u_dut8.r_wr_ptr, 8'h00);
    chk("rel_primed", {7'b0, pr8}, 8'h00);
    step8(1'b1, 8'h77);
    chk("rel_mem0", u_dut8.u_ram.r_mem[0], 8'h77);
    step8(1'b1, 8'h78);
    for (int i = 0; i < 3; i++) step8(1'b0, 8'h00);

    n_cmp++;
    assert ((expq[0].size() + expq[1].size()) === 0) else begin
      n_fail++;
      $error("FAIL drain got %0d want 0", expq[0].size() + expq[1].size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
